id_exe_stage: RTL and testbench

Parametrised ID/EXE pipeline register for the 16-bit THCO-MIPS16 core. It sits between decode and the ALU and replaces the fixed-width latch with a valid-tracked stage. Adds functional flush, N-channel operand forwarding, load-use bubble insertion, and complete operand selection for every opcode: no opcode leaves stale op1/op2. Instruction words are always 16 bits; datapath width and register-address width are parameters.

---
 rtl/id_exe_if.sv | 58 +++++
 rtl/id_exe_stage.sv | 166 ++++++++++++++++
 tb/tb_id_exe_stage.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_exe_if.sv
// Decode-to-EXE bundle for the THCO-MIPS16 ID/EXE stage: decode-side fields,
// forwarding channels, stage outputs and the load-use stall back to decode.
interface id_exe_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int FWD_CH = 2
);
    logic                     hold;
    logic                     flush;
    logic                     in_valid;
    logic [DATA_W-1:0]        pc;
    logic [15:0]              opn;
    logic                     mem_write;
    logic                     mem_read;
    logic                     reg_write;
    logic [REG_AW-1:0]        reg_addr;
    logic [REG_AW-1:0]        rs1_addr;
    logic [REG_AW-1:0]        rs2_addr;
    logic                     rs1_used;
    logic                     rs2_used;
    logic [DATA_W-1:0]        read_value1;
    logic [DATA_W-1:0]        read_value2;
    logic [FWD_CH-1:0]        fwd_valid;
    logic [FWD_CH*REG_AW-1:0] fwd_addr;
    logic [FWD_CH*DATA_W-1:0] fwd_value;

    logic                     out_valid;
    logic [DATA_W-1:0]        pc_out;
    logic [15:0]              opn_out;
    logic                     mem_write_out;
    logic                     mem_read_out;
    logic                     reg_write_out;
    logic [REG_AW-1:0]        reg_addr_out;
    logic [DATA_W-1:0]        op1;
    logic [DATA_W-1:0]        op2;
    logic [DATA_W-1:0]        mem_write_value;
    logic [DATA_W-1:0]        read_value1_output;
    logic [DATA_W-1:0]        read_value2_output;
    logic                     load_use_stall;

    modport master (
        output hold, flush, in_valid, pc, opn, mem_write, mem_read, reg_write, reg_addr,
               rs1_addr, rs2_addr, rs1_used, rs2_used, read_value1, read_value2,
               fwd_valid, fwd_addr, fwd_value,
        input  out_valid, pc_out, opn_out, mem_write_out, mem_read_out, reg_write_out,
               reg_addr_out, op1, op2, mem_write_value, read_value1_output,
               read_value2_output, load_use_stall
    );

    modport slave (
        input  hold, flush, in_valid, pc, opn, mem_write, mem_read, reg_write, reg_addr,
               rs1_addr, rs2_addr, rs1_used, rs2_used, read_value1, read_value2,
               fwd_valid, fwd_addr, fwd_value,
        output out_valid, pc_out, opn_out, mem_write_out, mem_read_out, reg_write_out,
               reg_addr_out, op1, op2, mem_write_value, read_value1_output,
               read_value2_output, load_use_stall
    );
endinterface

// File: rtl/id_exe_stage.sv
// THCO-MIPS16 ID/EXE pipeline register: valid tracking, flush, hold, operand
// forwarding, load-use bubble insertion and per-opcode ALU operand selection.
module id_exe_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int FWD_CH = 2
) (
    input logic     clk,
    input logic     rst,
    id_exe_if.slave bus
);
    localparam logic [15:0] NOP_OPN = 16'h0800;

    // Major opcodes (opn[15:11]) that select a non-zero operand.
    typedef enum logic [4:0] {
        OP_SHIFT  = 5'b00110,
        OP_ADDIU3 = 5'b01000,
        OP_ADDIU  = 5'b01001,
        OP_SP_GRP = 5'b01100,
        OP_LI     = 5'b01101,
        OP_MOVE   = 5'b01111,
        OP_LW_SP  = 5'b10010,
        OP_LW     = 5'b10011,
        OP_SW_SP  = 5'b11010,
        OP_SW     = 5'b11011,
        OP_RRR    = 5'b11100,
        OP_RR     = 5'b11101,
        OP_IH     = 5'b11110
    } opcode_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [15:0]       opn;
        logic              mem_write;
        logic              mem_read;
        logic              reg_write;
        logic [REG_AW-1:0] reg_addr;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] mem_write_value;
        logic [DATA_W-1:0] read_value1;
        logic [DATA_W-1:0] read_value2;
    } stage_t;

    function automatic stage_t bubble();
        stage_t b;
        b     = '0;
        b.opn = NOP_OPN;
        return b;
    endfunction

    stage_t            stage_q, stage_d;
    logic [DATA_W-1:0] fv1, fv2;
    logic [DATA_W-1:0] op1_d, op2_d;
    logic [DATA_W-1:0] imm_s8, imm_s5, imm_s4, imm_z8, shamt;
    opcode_e           major;
    logic              stall;

    // Scanning from the oldest channel down lets the youngest match win.
    always_comb begin
        fv1 = bus.read_value1;
        fv2 = bus.read_value2;
        for (int i = FWD_CH - 1; i >= 0; i--) begin
            if (bus.rs1_used && bus.fwd_valid[i] &&
                bus.fwd_addr[i*REG_AW +: REG_AW] == bus.rs1_addr)
                fv1 = bus.fwd_value[i*DATA_W +: DATA_W];
            if (bus.rs2_used && bus.fwd_valid[i] &&
                bus.fwd_addr[i*REG_AW +: REG_AW] == bus.rs2_addr)
                fv2 = bus.fwd_value[i*DATA_W +: DATA_W];
        end
    end

    assign stall = stage_q.valid && stage_q.mem_read && stage_q.reg_write && bus.in_valid &&
                   ((bus.rs1_used && bus.rs1_addr == stage_q.reg_addr) ||
                    (bus.rs2_used && bus.rs2_addr == stage_q.reg_addr));

    assign major  = opcode_e'(bus.opn[15:11]);
    assign imm_s8 = {{(DATA_W-8){bus.opn[7]}}, bus.opn[7:0]};
    assign imm_s5 = {{(DATA_W-5){bus.opn[4]}}, bus.opn[4:0]};
    assign imm_s4 = {{(DATA_W-4){bus.opn[3]}}, bus.opn[3:0]};
    assign imm_z8 = {{(DATA_W-8){1'b0}}, bus.opn[7:0]};
    // A zero shift field means a shift by eight.
    assign shamt  = {{(DATA_W-4){1'b0}}, (bus.opn[4:2] == 3'd0) ? 4'd8 : {1'b0, bus.opn[4:2]}};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        op1_d = '0;
        op2_d = '0;
        case (major)
            OP_ADDIU, OP_LW_SP, OP_SW_SP: begin op1_d = fv1; op2_d = imm_s8; end
            OP_ADDIU3:                    begin op1_d = fv1; op2_d = imm_s4; end
            OP_LW, OP_SW:                 begin op1_d = fv1; op2_d = imm_s5; end
            OP_LI:                        op1_d = imm_z8;
            OP_MOVE:                      op1_d = fv2;
            OP_SP_GRP: begin
                if (bus.opn[10:8] == 3'b011) begin op1_d = fv1; op2_d = imm_s8; end // ADDSP
                else if (bus.opn[10:8] == 3'b100) op1_d = fv1;                     // MTSP
            end
            OP_SHIFT: begin
                if (bus.opn[1:0] != 2'b01) begin op1_d = fv2; op2_d = shamt; end
            end
            OP_RRR: begin
                if (bus.opn[0]) begin op1_d = fv1; op2_d = fv2; end                // ADDU, SUBU
            end
            OP_RR: begin
                case (bus.opn[4:0])
                    5'b00000: if (bus.opn[7:5] == 3'b010) op1_d = bus.pc;           // MFPC
                    5'b01100, 5'b01101, 5'b01010, 5'b00111: begin
                        op1_d = fv1;
                        op2_d = fv2;
                    end
                    default: ;
                endcase
            end
            OP_IH: begin
                if (bus.opn[7:1] == 7'd0) op1_d = fv1;                              // MFIH, MTIH
            end
            default: ;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = bubble();
        end else if (bus.hold) begin
            stage_d = stage_q;
        end else if (stall || !bus.in_valid) begin
            stage_d = bubble();
        end else begin
            stage_d.valid           = 1'b1;
            stage_d.pc              = bus.pc;
            stage_d.opn             = bus.opn;
            stage_d.mem_write       = bus.mem_write;
            stage_d.mem_read        = bus.mem_read;
            stage_d.reg_write       = bus.reg_write;
            stage_d.reg_addr        = bus.reg_addr;
            stage_d.op1             = op1_d;
            stage_d.op2             = op2_d;
            stage_d.mem_write_value = fv2;
            stage_d.read_value1     = fv1;
            stage_d.read_value2     = fv2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= bubble();
        else     stage_q <= stage_d;
    end

    assign bus.out_valid          = stage_q.valid;
    assign bus.pc_out             = stage_q.pc;
    assign bus.opn_out            = stage_q.opn;
    assign bus.mem_write_out      = stage_q.mem_write;
    assign bus.mem_read_out       = stage_q.mem_read;
    assign bus.reg_write_out      = stage_q.reg_write;
    assign bus.reg_addr_out       = stage_q.reg_addr;
    assign bus.op1                = stage_q.op1;
    assign bus.op2                = stage_q.op2;
    assign bus.mem_write_value    = stage_q.mem_write_value;
    assign bus.read_value1_output = stage_q.read_value1;
    assign bus.read_value2_output = stage_q.read_value2;
    assign bus.load_use_stall     = stall;
endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: mnemonic-level reference model checked every cycle,
// plus hand-computed expectations for reset, decode, forwarding, stalls, flush and hold.
module tb_id_exe_stage;
    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int FWD_CH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_exe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_CH(FWD_CH)) bus ();

    id_exe_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_CH(FWD_CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;
    logic [15:0] pc_cnt = 16'h0011;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {
        M_ADDIU, M_ADDIU3, M_ADDSP, M_MTSP, M_LW_SP, M_SW_SP, M_LW, M_SW, M_LI, M_MOVE,
        M_MFPC, M_MFIH, M_MTIH, M_SLL, M_SRA, M_SRL, M_ADDU, M_SUBU, M_AND, M_OR, M_CMP,
        M_SRAV, M_OTHER
    } mnem_e;

    typedef struct {
        logic        valid;
        logic [15:0] pc, opn;
        logic        mw, mr, rw;
        logic [3:0]  ra;
        logic [15:0] op1, op2, mwv, rv1, rv2;
    } exp_t;

    exp_t exp_s;

    function automatic exp_t bubble();
        exp_t b;
        b.valid = 0; b.pc = 0; b.opn = 16'h0800; b.mw = 0; b.mr = 0; b.rw = 0; b.ra = 0;
        b.op1 = 0; b.op2 = 0; b.mwv = 0; b.rv1 = 0; b.rv2 = 0;
        return b;
    endfunction

    function automatic mnem_e mnem(input logic [15:0] o);
        case (o[15:11])
            5'b01001: return M_ADDIU;
            5'b01000: return M_ADDIU3;
            5'b01100: return (o[10:8] == 3'b011) ? M_ADDSP : (o[10:8] == 3'b100) ? M_MTSP : M_OTHER;
            5'b10010: return M_LW_SP;
            5'b11010: return M_SW_SP;
            5'b10011: return M_LW;
            5'b11011: return M_SW;
            5'b01101: return M_LI;
            5'b01111: return M_MOVE;
            5'b00110: return (o[1:0] == 2'b00) ? M_SLL : (o[1:0] == 2'b11) ? M_SRA :
                             (o[1:0] == 2'b10) ? M_SRL : M_OTHER;
            5'b11100: return (o[1:0] == 2'b01) ? M_ADDU : (o[1:0] == 2'b11) ? M_SUBU : M_OTHER;
            5'b11101: begin
                if (o[4:0] == 5'b00000 && o[7:5] == 3'b010) return M_MFPC;
                if (o[4:0] == 5'b01100) return M_AND;
                if (o[4:0] == 5'b01101) return M_OR;
                if (o[4:0] == 5'b01010) return M_CMP;
                if (o[4:0] == 5'b00111) return M_SRAV;
                return M_OTHER;
            end
            5'b11110: return (o[7:0] == 8'd0) ? M_MFIH : (o[7:0] == 8'd1) ? M_MTIH : M_OTHER;
            default:  return M_OTHER;
        endcase
    endfunction

    function automatic logic [15:0] sx(input int v, input int bits);
        int r;
        r = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
        return 16'(r);
    endfunction

    function automatic logic [15:0] fwd(input logic [3:0] a, input logic used, input logic [15:0] rf);
        logic [15:0] r;
        bit found;
        r = rf;
        found = 0;
        if (used)
            for (int i = 0; i < FWD_CH; i++)
                if (!found && bus.fwd_valid[i] && bus.fwd_addr[i*REG_AW +: REG_AW] == a) begin
                    r = bus.fwd_value[i*DATA_W +: DATA_W];
                    found = 1;
                end
        return r;
    endfunction

    function automatic logic model_stall();
        return exp_s.valid && exp_s.mr && exp_s.rw && bus.in_valid &&
               ((bus.rs1_used && bus.rs1_addr == exp_s.ra) || (bus.rs2_used && bus.rs2_addr == exp_s.ra));
    endfunction

    function automatic exp_t model_next();
        exp_t n;
        logic [15:0] f1, f2;
        int sh;
        if (bus.flush) return bubble();
        if (bus.hold) return exp_s;
        if (model_stall() || !bus.in_valid) return bubble();
        f1 = fwd(bus.rs1_addr, bus.rs1_used, bus.read_value1);
        f2 = fwd(bus.rs2_addr, bus.rs2_used, bus.read_value2);
        n.valid = 1; n.pc = bus.pc; n.opn = bus.opn; n.mw = bus.mem_write; n.mr = bus.mem_read;
        n.rw = bus.reg_write; n.ra = bus.reg_addr; n.rv1 = f1; n.rv2 = f2; n.mwv = f2;
        n.op1 = 0; n.op2 = 0;
        sh = int'(bus.opn[4:2]);
        case (mnem(bus.opn))
            M_ADDIU, M_ADDSP, M_LW_SP, M_SW_SP: begin n.op1 = f1; n.op2 = sx(int'(bus.opn[7:0]), 8); end
            M_ADDIU3:                 begin n.op1 = f1; n.op2 = sx(int'(bus.opn[3:0]), 4); end
            M_LW, M_SW:               begin n.op1 = f1; n.op2 = sx(int'(bus.opn[4:0]), 5); end
            M_LI:                     n.op1 = 16'(int'(bus.opn[7:0]));
            M_MOVE:                   n.op1 = f2;
            M_MFPC:                   n.op1 = bus.pc;
            M_MFIH, M_MTIH, M_MTSP:   n.op1 = f1;
            M_SLL, M_SRA, M_SRL:      begin n.op1 = f2; n.op2 = 16'((sh == 0) ? 8 : sh); end
            M_ADDU, M_SUBU, M_AND, M_OR, M_CMP, M_SRAV: begin n.op1 = f1; n.op2 = f2; end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) exp_s = bubble();
        else     exp_s = model_next();
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("m_out_valid", bus.out_valid, exp_s.valid);
            check("m_pc_out", bus.pc_out, exp_s.pc);
            check("m_opn_out", bus.opn_out, exp_s.opn);
            check("m_mem_write_out", bus.mem_write_out, exp_s.mw);
            check("m_mem_read_out", bus.mem_read_out, exp_s.mr);
            check("m_reg_write_out", bus.reg_write_out, exp_s.rw);
            check("m_reg_addr_out", bus.reg_addr_out, exp_s.ra);
            check("m_op1", bus.op1, exp_s.op1);
            check("m_op2", bus.op2, exp_s.op2);
            check("m_mem_write_value", bus.mem_write_value, exp_s.mwv);
            check("m_rv1_out", bus.read_value1_output, exp_s.rv1);
            check("m_rv2_out", bus.read_value2_output, exp_s.rv2);
            check("m_load_use_stall", bus.load_use_stall, model_stall());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.hold = 0; bus.flush = 0; bus.in_valid = 0; bus.pc = 0; bus.opn = 0;
        bus.mem_write = 0; bus.mem_read = 0; bus.reg_write = 0; bus.reg_addr = 0;
        bus.rs1_addr = 0; bus.rs2_addr = 0; bus.rs1_used = 0; bus.rs2_used = 0;
        bus.read_value1 = 0; bus.read_value2 = 0;
        bus.fwd_valid = '0; bus.fwd_addr = '0; bus.fwd_value = '0;
    endtask

    task automatic issue(input logic [15:0] opn, input logic [3:0] ra, input logic rw,
                         input logic mr, input logic mw,
                         input logic [3:0] rs1, input logic u1, input logic [15:0] rv1,
                         input logic [3:0] rs2, input logic u2, input logic [15:0] rv2);
        bus.in_valid = 1; bus.pc = pc_cnt; pc_cnt = pc_cnt + 16'd1; bus.opn = opn;
        bus.reg_addr = ra; bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw;
        bus.rs1_addr = rs1; bus.rs1_used = u1; bus.read_value1 = rv1;
        bus.rs2_addr = rs2; bus.rs2_used = u2; bus.read_value2 = rv2;
        bus.fwd_valid = '0; bus.fwd_addr = '0; bus.fwd_value = '0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_opn_out", bus.opn_out, 16'h0800);
        check("reset_op1", bus.op1, 16'h0000);
        rst = 0;
        model_on = 1;

        // ADDIU R2,-1 then SLL R1,R0,0
        issue(16'h4AFF, 4'd2, 1, 0, 0, 4'd2, 1, 16'h0005, 4'd0, 0, 16'h0000);
        tick();
        check("addiu_out_valid", bus.out_valid, 1'b1);
        check("addiu_pc_out", bus.pc_out, 16'h0011);
        check("addiu_op1", bus.op1, 16'h0005);
        check("addiu_op2", bus.op2, 16'hFFFF);
        issue(16'h3100, 4'd1, 1, 0, 0, 4'd0, 0, 16'h0000, 4'd0, 1, 16'h0007);
        tick();
        check("sll_op1", bus.op1, 16'h0007);
        check("sll_op2_eight", bus.op2, 16'h0008);

        // Forwarding priority on ADDU R3,R4
        issue(16'hE395, 4'd5, 1, 0, 0, 4'd3, 1, 16'hAAAA, 4'd4, 1, 16'h0004);
        bus.fwd_valid = 2'b11; bus.fwd_addr = {4'd3, 4'd3}; bus.fwd_value = {16'h2222, 16'h1111};
        tick();
        check("fwd_ch0_wins", bus.op1, 16'h1111);
        check("fwd_op2_regfile", bus.op2, 16'h0004);
        bus.fwd_valid = 2'b10;
        tick();
        check("fwd_ch1_only", bus.op1, 16'h2222);
        bus.rs1_used = 0;
        tick();
        check("fwd_unused_ignored", bus.op1, 16'hAAAA);

        // Load-use: LW R2 in stage, ADDU reading R2 in decode
        issue(16'h9943, 4'd2, 1, 1, 0, 4'd1, 1, 16'h0100, 4'd2, 0, 16'h0000);
        tick();
        check("lw_op2", bus.op2, 16'h0003);
        check("lw_mem_read_out", bus.mem_read_out, 1'b1);
        issue(16'hE14D, 4'd3, 1, 0, 0, 4'd1, 1, 16'h0010, 4'd2, 1, 16'h0020);
        #1;
        check("lu_stall_high", bus.load_use_stall, 1'b1);
        tick();
        check("lu_bubble_valid", bus.out_valid, 1'b0);
        check("lu_bubble_opn", bus.opn_out, 16'h0800);
        check("lu_stall_cleared", bus.load_use_stall, 1'b0);
        tick();
        check("lu_capture_valid", bus.out_valid, 1'b1);
        check("lu_capture_opn", bus.opn_out, 16'hE14D);
        check("lu_capture_op2", bus.op2, 16'h0020);

        // flush wins over hold with SW in the stage
        issue(16'hD944, 4'd0, 0, 0, 1, 4'd1, 1, 16'h0200, 4'd2, 1, 16'hBEEF);
        tick();
        check("sw_mem_write_out", bus.mem_write_out, 1'b1);
        check("sw_mem_write_value", bus.mem_write_value, 16'hBEEF);
        check("sw_op2", bus.op2, 16'h0004);
        bus.hold = 1; bus.flush = 1;
        tick();
        check("flush_mem_write_out", bus.mem_write_out, 1'b0);
        check("flush_opn_out", bus.opn_out, 16'h0800);
        check("flush_out_valid", bus.out_valid, 1'b0);
        bus.hold = 0; bus.flush = 0;

        // hold for three cycles with LI R3,0x80 in the stage while inputs change
        issue(16'h6B80, 4'd3, 1, 0, 0, 4'd0, 0, 16'h0000, 4'd0, 0, 16'h0000);
        tick();
        check("li_op1_zext", bus.op1, 16'h0080);
        bus.hold = 1;
        for (int k = 0; k < 3; k++) begin
            issue(16'h4148 + 16'(k), 4'd1, 1, 1, 1, 4'd2, 1, 16'h0F00 + 16'(k), 4'd3, 1, 16'h1234);
            tick();
            check("hold_op1", bus.op1, 16'h0080);
            check("hold_opn_out", bus.opn_out, 16'h6B80);
            check("hold_reg_addr_out", bus.reg_addr_out, 4'd3);
        end
        bus.hold = 0;

        // hold keeps a pending load-use stall asserted
        issue(16'h9943, 4'd2, 1, 1, 0, 4'd1, 1, 16'h0100, 4'd0, 0, 16'h0000);
        tick();
        issue(16'hE14D, 4'd3, 1, 0, 0, 4'd1, 1, 16'h0010, 4'd2, 1, 16'h0020);
        bus.hold = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("hold_stall_high", bus.load_use_stall, 1'b1);
            check("hold_stall_opn", bus.opn_out, 16'h9943);
        end
        bus.hold = 0;
        tick();
        check("hold_stall_bubble", bus.out_valid, 1'b0);
        tick();
        check("hold_stall_capture", bus.opn_out, 16'hE14D);

        // Opcode sweep checked against the model
        issue(16'h7980, 4'd1, 1, 0, 0, 4'd0, 0, 16'h0000, 4'd4, 1, 16'h1234); tick(); // MOVE
        issue(16'hEA40, 4'd2, 1, 0, 0, 4'd0, 0, 16'h0000, 4'd0, 0, 16'h0000); tick(); // MFPC
        issue(16'hF100, 4'd1, 1, 0, 0, 4'd9, 1, 16'h00AB, 4'd0, 0, 16'h0000); tick(); // MFIH
        issue(16'h6380, 4'd8, 1, 0, 0, 4'd8, 1, 16'h1000, 4'd0, 0, 16'h0000); tick(); // ADDSP
        check("addsp_op2", bus.op2, 16'hFF80);
        issue(16'h4148, 4'd2, 1, 0, 0, 4'd1, 1, 16'h0009, 4'd0, 0, 16'h0000); tick(); // ADDIU3
        check("addiu3_op2", bus.op2, 16'hFFF8);
        issue(16'h937F, 4'd3, 1, 1, 0, 4'd8, 1, 16'h2000, 4'd0, 0, 16'h0000); tick(); // LW_SP
        issue(16'h314F, 4'd1, 1, 0, 0, 4'd0, 0, 16'h0000, 4'd2, 1, 16'h8000);         // SRA
        bus.fwd_valid = 2'b10; bus.fwd_addr = {4'd2, 4'd7}; bus.fwd_value = {16'h5A5A, 16'hFFFF};
        tick();
        check("sra_fwd_op1", bus.op1, 16'h5A5A);
        check("sra_op2", bus.op2, 16'h0003);
        issue(16'hE94C, 4'd1, 1, 0, 0, 4'd1, 1, 16'h0F0F, 4'd2, 1, 16'h00FF); tick(); // AND
        issue(16'h1010, 4'd0, 0, 0, 0, 4'd0, 0, 16'h1111, 4'd0, 0, 16'h2222); tick(); // B
        issue(16'hEB00, 4'd0, 0, 0, 0, 4'd3, 1, 16'h3333, 4'd0, 0, 16'h0000); tick(); // JR
        issue(16'hF800, 4'd0, 0, 0, 0, 4'd1, 1, 16'h4444, 4'd2, 1, 16'h5555); tick(); // undefined
        issue(16'h4AFF, 4'd2, 1, 0, 0, 4'd2, 1, 16'h0005, 4'd0, 0, 16'h0000);
        bus.in_valid = 0; tick();                                                       // not valid
        issue(16'h995F, 4'd2, 1, 1, 0, 4'd1, 1, 16'h0300, 4'd0, 0, 16'h0000); tick(); // LW imm -1
        check("lw_neg_op2", bus.op2, 16'hFFFF);
        issue(16'hE273, 4'd4, 1, 0, 0, 4'd2, 1, 16'h0001, 4'd3, 1, 16'h0002); tick(); // SUBU, stalls
        issue(16'hE94C, 4'd1, 1, 0, 0, 4'd1, 1, 16'h00F0, 4'd2, 1, 16'h0F00); tick();

        // Mid-cycle reset while hold is set
        issue(16'h4AFF, 4'd2, 1, 0, 0, 4'd2, 1, 16'h0005, 4'd0, 0, 16'h0000);
        tick();
        bus.hold = 1;
        tick();
        #1 rst = 1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_opn_out", bus.opn_out, 16'h0800);
        check("midrst_op2", bus.op2, 16'h0000);
        check("midrst_pc_out", bus.pc_out, 16'h0000);
        check("midrst_reg_write_out", bus.reg_write_out, 1'b0);
        #1 rst = 0;
        bus.hold = 0;
        issue(16'h6B80, 4'd3, 1, 0, 0, 4'd0, 0, 16'h0000, 4'd0, 0, 16'h0000);
        tick();
        check("after_rst_capture", bus.out_valid, 1'b1);
        check("after_rst_op1", bus.op1, 16'h0080);
        idle();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
